// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx                                                       |
// | Purpose  : 8N1 serial receiver for the jacaranda-8 memory-mapped UART.   |
// |            A 2-flop synchronizer feeds an IDLE/START/DATA/STOP FSM that  |
// |            samples mid-bit. It raises receive_flag/int_req on a good     |
// |            frame and a sticky frame_err on a low stop bit.               |
// | Options  : UART_RX_OVERRUN_EN adds the overrun output and status bit 2.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx #(
   parameter int CLKS_PER_BIT = 1042
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_n_i,
   input  logic       rx,
   input  logic       rx_en,
   input  logic [7:0] access_addr,
   input  logic       reg_w_en,
   output logic [7:0] rx_data,
   output logic       receive_flag,
   output logic       int_req,
   output logic       frame_err,
`ifdef UART_RX_OVERRUN_EN
   output logic       overrun,
`endif
   output logic [7:0] status
);

   localparam int             c_CW       = $clog2(CLKS_PER_BIT);
   localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'((CLKS_PER_BIT >> 1) - 1);
   localparam logic [c_CW-1:0] c_BIT_M1  = c_CW'(CLKS_PER_BIT - 1);
   localparam logic [7:0]      c_RD_ADDR = 8'd252;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [c_CW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]      r_idx, w_idx_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic            r_rx_meta, r_rx_s;
   logic            w_good, w_bad, w_clr;

   // The CPU reading the data register acknowledges the pending byte
   assign w_clr = reg_w_en && (access_addr == c_RD_ADDR);

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // FSM state, bit timer, bit index and shift register
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   // Next-state logic: start bit checked mid-bit, data/stop one bit later each
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + c_CW'(1);
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            if (rx_en && !r_rx_s) w_state_nxt = S_START;
         end
         S_START: begin
            if (r_cnt == c_HALF_M1) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               // A line that is high again at mid-start was only a glitch
               w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == c_BIT_M1) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_idx] = r_rx_s;
               if (r_idx == 3'd7) w_state_nxt = S_STOP;
               else               w_idx_nxt   = r_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (r_cnt == c_BIT_M1) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
               w_good      = r_rx_s;
               w_bad       = !r_rx_s;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      // Disabling the receiver abandons any partial frame
      if (!rx_en && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
         w_good      = 1'b0;
         w_bad       = 1'b0;
      end
   end

   // CPU-visible registers; a completing frame takes priority over the clear
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         rx_data      <= 8'h00;
         receive_flag <= 1'b0;
         int_req      <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         if (w_good) begin
            rx_data      <= r_shift;
            receive_flag <= 1'b1;
            frame_err    <= 1'b0;
         end else if (w_clr) begin
            receive_flag <= 1'b0;
         end
         if (w_bad) frame_err <= 1'b1;
         int_req <= receive_flag & rx_en;
      end
   end

`ifdef UART_RX_OVERRUN_EN
   // Overrun: a good byte landed on top of an unread one with no read in flight
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)                      overrun <= 1'b0;
      else if (w_clr)                       overrun <= 1'b0;
      else if (w_good && receive_flag)      overrun <= 1'b1;
   end

   assign status = {5'b0, overrun, receive_flag, 1'b0};
`else
   assign status = {5'b0, 1'b0, receive_flag, 1'b0};
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                    |
// | Purpose  : Self-checking bench for uart_rx at 16 clocks per bit. Good    |
// |            frames push their byte into a queue that the tests pop on     |
// |            completion. Honours UART_RX_OVERRUN_EN.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx;

   localparam int c_CPB = 16;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_n_i = 1'b0;
   logic       rx = 1'b1;
   logic       rx_en = 1'b1;
   logic [7:0] access_addr = 8'h00;
   logic       reg_w_en = 1'b0;
   logic [7:0] rx_data;
   logic       receive_flag, int_req, frame_err;
   logic [7:0] status;
`ifdef UART_RX_OVERRUN_EN
   logic       overrun;
   localparam bit c_OVR = 1'b1;
`else
   logic       overrun;
   assign overrun = 1'b0;
   localparam bit c_OVR = 1'b0;
`endif

   uart_rx #(.CLKS_PER_BIT(c_CPB)) dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_n_i   (wb_rst_n_i),
      .rx           (rx),
      .rx_en        (rx_en),
      .access_addr  (access_addr),
      .reg_w_en     (reg_w_en),
      .rx_data      (rx_data),
      .receive_flag (receive_flag),
      .int_req      (int_req),
      .frame_err    (frame_err),
`ifdef UART_RX_OVERRUN_EN
      .overrun      (overrun),
`endif
      .status       (status)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         fall_cyc = 0;
   int         flag_rise_cyc = -1;
   int         int_rise_cyc = -1;
   logic       prev_flag = 1'b0;
   logic       prev_int = 1'b0;
   logic [7:0] sb_q[$];
   logic [7:0] exp_b;

   // Cycle counter and rise-time monitor for the latency checks
   always @(posedge wb_clk_i) cyc <= cyc + 1;
   always @(negedge wb_clk_i) begin
      if (receive_flag && !prev_flag) flag_rise_cyc = cyc;
      if (int_req && !prev_int)       int_rise_cyc  = cyc;
      prev_flag = receive_flag;
      prev_int  = int_req;
   end

   // Drives one 8N1 frame starting at the current negedge; good frames are
   // pushed onto the scoreboard when 'expect_it' is set
   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input bit expect_it, input int gap);
      if (expect_it && stop_bit) sb_q.push_back(d);
      rx = 1'b0;
      fall_cyc = cyc;
      repeat (c_CPB) @(negedge wb_clk_i);
      for (int k = 0; k < 8; k++) begin
         rx = d[k];
         repeat (c_CPB) @(negedge wb_clk_i);
      end
      rx = stop_bit;
      repeat (c_CPB) @(negedge wb_clk_i);
      rx = 1'b1;
      repeat (gap) @(negedge wb_clk_i);
   endtask

   task automatic pop_expected();
      if (sb_q.size() == 0) begin
         fails++;
         $display("FAIL scoreboard_empty: got no queued byte, required one");
         exp_b = 8'hxx;
      end else begin
         exp_b = sb_q.pop_front();
      end
   endtask

   task automatic test_reset();
      @(negedge wb_clk_i);
      tests++; if ({rx_data, receive_flag, int_req, frame_err, overrun} !== 12'h000) begin
         fails++; $display("FAIL reset_outputs: got %h, required 000",
                           {rx_data, receive_flag, int_req, frame_err, overrun});
      end
      tests++; if (status !== 8'h00) begin
         fails++; $display("FAIL reset_status: got %h, required 00", status);
      end
      wb_rst_n_i = 1'b1;
      repeat (4) @(negedge wb_clk_i);
      tests++; if ({receive_flag, int_req, frame_err} !== 3'b000) begin
         fails++; $display("FAIL post_reset_flags: got %b, required 000",
                           {receive_flag, int_req, frame_err});
      end
   endtask

   task automatic test_single();
      flag_rise_cyc = -1;
      int_rise_cyc  = -1;
      send_frame(8'hA5, 1'b1, 1'b1, 4);
      pop_expected();
      tests++; if (rx_data !== exp_b) begin
         fails++; $display("FAIL single_data: got %h, required %h", rx_data, exp_b);
      end
      tests++; if (receive_flag !== 1'b1 || int_req !== 1'b1) begin
         fails++; $display("FAIL single_flags: got %b%b, required 11", receive_flag, int_req);
      end
      tests++; if (flag_rise_cyc - fall_cyc !== 155) begin
         fails++; $display("FAIL single_flag_latency: got %0d, required 155",
                           flag_rise_cyc - fall_cyc);
      end
      tests++; if (int_rise_cyc - flag_rise_cyc !== 1) begin
         fails++; $display("FAIL single_int_latency: got %0d, required 1",
                           int_rise_cyc - flag_rise_cyc);
      end
      tests++; if (status !== 8'h02) begin
         fails++; $display("FAIL single_status: got %h, required 02", status);
      end
   endtask

   task automatic test_clear();
      access_addr = 8'd252; reg_w_en = 1'b1;
      @(negedge wb_clk_i);
      access_addr = 8'd0; reg_w_en = 1'b0;
      tests++; if (receive_flag !== 1'b0 || int_req !== 1'b1) begin
         fails++; $display("FAIL clear_step1: got flag=%b int=%b, required flag=0 int=1",
                           receive_flag, int_req);
      end
      @(negedge wb_clk_i);
      tests++; if (int_req !== 1'b0 || rx_data !== 8'hA5) begin
         fails++; $display("FAIL clear_step2: got int=%b data=%h, required int=0 data=a5",
                           int_req, rx_data);
      end
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      repeat (5) @(negedge wb_clk_i);
      rx = 1'b1;
      repeat (30) @(negedge wb_clk_i);
      tests++; if ({receive_flag, frame_err, rx_data} !== {2'b00, 8'hA5}) begin
         fails++; $display("FAIL glitch_state: got flag=%b ferr=%b data=%h, required 0 0 a5",
                           receive_flag, frame_err, rx_data);
      end
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0, 1'b1, 24);
      tests++; if ({frame_err, receive_flag, rx_data} !== {2'b10, 8'hA5}) begin
         fails++; $display("FAIL ferr_set: got ferr=%b flag=%b data=%h, required 1 0 a5",
                           frame_err, receive_flag, rx_data);
      end
      send_frame(8'h01, 1'b1, 1'b1, 4);
      pop_expected();
      tests++; if ({frame_err, receive_flag, rx_data} !== {2'b01, exp_b}) begin
         fails++; $display("FAIL ferr_clear: got ferr=%b flag=%b data=%h, required 0 1 %h",
                           frame_err, receive_flag, rx_data, exp_b);
      end
   endtask

   task automatic test_back_to_back();
      // Acknowledge the pending byte so overrun starts from a clean slate
      access_addr = 8'd252; reg_w_en = 1'b1;
      @(negedge wb_clk_i);
      access_addr = 8'd0; reg_w_en = 1'b0;
      repeat (2) @(negedge wb_clk_i);
      send_frame(8'h11, 1'b1, 1'b1, 0);
      pop_expected();
      tests++; if (rx_data !== exp_b || overrun !== 1'b0) begin
         fails++; $display("FAIL b2b_first: got data=%h ovr=%b, required %h 0",
                           rx_data, overrun, exp_b);
      end
      send_frame(8'h22, 1'b1, 1'b1, 4);
      pop_expected();
      tests++; if ({rx_data, receive_flag, overrun} !== {exp_b, 1'b1, c_OVR}) begin
         fails++; $display("FAIL b2b_overrun: got data=%h flag=%b ovr=%b, required %h 1 %b",
                           rx_data, receive_flag, overrun, exp_b, c_OVR);
      end
      tests++; if (status !== {5'b0, c_OVR, 2'b10}) begin
         fails++; $display("FAIL b2b_status: got %h, required %h", status, {5'b0, c_OVR, 2'b10});
      end
   endtask

   task automatic test_set_wins();
      fork
         send_frame(8'h33, 1'b1, 1'b1, 4);
         begin
            repeat (154) @(negedge wb_clk_i);
            access_addr = 8'd252; reg_w_en = 1'b1;
            @(negedge wb_clk_i);
            access_addr = 8'd0; reg_w_en = 1'b0;
         end
      join
      pop_expected();
      tests++; if ({rx_data, receive_flag, overrun} !== {exp_b, 1'b1, 1'b0}) begin
         fails++; $display("FAIL set_wins: got data=%h flag=%b ovr=%b, required %h 1 0",
                           rx_data, receive_flag, overrun, exp_b);
      end
   endtask

   task automatic test_abort();
      fork
         send_frame(8'hF0, 1'b1, 1'b0, 24);
         begin
            repeat (11 + 3 * c_CPB) @(negedge wb_clk_i);
            rx_en = 1'b0;
         end
      join
      tests++; if ({rx_data, receive_flag, int_req, frame_err} !== {8'h33, 3'b100}) begin
         fails++; $display("FAIL abort_retain: got data=%h flag=%b int=%b ferr=%b, required 33 1 0 0",
                           rx_data, receive_flag, int_req, frame_err);
      end
      rx_en = 1'b1;
      repeat (2) @(negedge wb_clk_i);
      tests++; if (int_req !== 1'b1 || rx_data !== 8'h33) begin
         fails++; $display("FAIL abort_reenable: got int=%b data=%h, required 1 33", int_req, rx_data);
      end
   endtask

   task automatic test_reset_midframe();
      fork
         send_frame(8'hC3, 1'b1, 1'b0, 8);
         begin
            repeat (80) @(negedge wb_clk_i);
            #2 wb_rst_n_i = 1'b0;
            #1;
            tests++; if ({rx_data, receive_flag, int_req, frame_err, overrun} !== 12'h000) begin
               fails++; $display("FAIL reset_async: got %h, required 000",
                                 {rx_data, receive_flag, int_req, frame_err, overrun});
            end
         end
      join
      wb_rst_n_i = 1'b1;
      repeat (4) @(negedge wb_clk_i);
      send_frame(8'h5A, 1'b1, 1'b1, 4);
      pop_expected();
      tests++; if ({rx_data, receive_flag, frame_err} !== {exp_b, 2'b10}) begin
         fails++; $display("FAIL reset_recover: got data=%h flag=%b ferr=%b, required %h 1 0",
                           rx_data, receive_flag, frame_err, exp_b);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_clear();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_set_wins();
      test_abort();
      test_reset_midframe();
      tests++; if (sb_q.size() != 0) begin
         fails++; $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the jacaranda-8 memory-mapped UART. It turns the `rx` pin into bytes for the CPU, and is the receive-side partner of the transmit path driven by `tx_data`/`begin_flag`. The CPU reads the received byte at data address 252 and the status bits at address 254. A completed byte raises `receive_flag` and a level interrupt request `int_req`. Both clear when the CPU loads address 252 into a register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1042: `wb_clk_i` cycles per bit (10 MHz / 9600 baud); legal range ≥ 4.

Ports:
- `wb_clk_i`  in  1  system clock; all state is on the rising edge.
- `wb_rst_n_i`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial input pin, asynchronous, idles high.
- `rx_en`  in  1  receiver enable (bit 1 of control register 255).
- `access_addr`  in  8  CPU data-memory address (`rs_data`).
- `reg_w_en`  in  1  CPU register-file write strobe; together with `access_addr`==252 it marks a read of the received byte.
- `rx_data`  out  8  last correctly framed byte.
- `receive_flag`  out  1  unread byte is present.
- `int_req`  out  1  interrupt request, level.
- `frame_err`  out  1  the last frame had a low stop bit (sticky).

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- **State machine:** four states, IDLE, START, DATA and STOP, driven by a bit counter `cnt` and a bit index `idx` (0..7). `HALF` = `CLKS_PER_BIT`>>1.
  - IDLE: if `rx_en`=1 and `rx_s`=0, go to START with `cnt`=0.
  - START: at `cnt`==`HALF`-1, sample `rx_s`. If it is 0, go to DATA with `cnt`=0 and `idx`=0. If it is 1, treat it as a glitch and return to IDLE.
  - DATA: at `cnt`==`CLKS_PER_BIT`-1, sample `rx_s` into shift bit `idx` (LSB first) and reset `cnt` to 0. After `idx`=7, go to STOP.
  - STOP: at `cnt`==`CLKS_PER_BIT`-1, sample the stop bit and return to IDLE.
    - Stop bit 1: load `rx_data` from the shift register, set `receive_flag`, clear `frame_err`.
    - Stop bit 0: set `frame_err`; `rx_data` and `receive_flag` are unchanged.
- **Flag clear:** when `access_addr`==252 and `reg_w_en`=1, `receive_flag` is cleared on the next edge.
- **`int_req`:** `int_req` = `receive_flag` & `rx_en`, registered.
- **`rx_en` deasserted:**
  - in any non-IDLE state, the FSM returns to IDLE on the next edge and the partial byte is discarded;
  - `rx_data`, `receive_flag` and `frame_err` are retained.
- **Simultaneous events:**
  - A good-stop completion and a clear in the same cycle: set wins, and `receive_flag` stays 1.
  - A new byte completing while `receive_flag`=1: `rx_data` is overwritten with the new byte.
- **Reset:** reset asserted mid-frame aborts the frame immediately; state and all registers take their reset values asynchronously.

## Timing
- **Reset values:**
  - `rx_data`=8'h00, `receive_flag`=0, `int_req`=0, `frame_err`=0;
  - FSM in IDLE, `cnt`=0, `idx`=0.
- **Latency:** the falling edge of the start bit on `rx` appears in `rx_s` 2 cycles later.
- **Sample points:** relative to the first cycle with `rx_s`=0,
  - the start bit is sampled `HALF` cycles later;
  - data bit k is sampled `HALF`+(k+1)·`CLKS_PER_BIT` cycles later;
  - the stop bit is sampled `HALF`+9·`CLKS_PER_BIT` cycles later.
- **Completion:** `receive_flag`, `rx_data` and `frame_err` update on the edge that ends the stop sample cycle. `int_req` follows `receive_flag` one cycle later.
- **Back-to-back frames:** a start bit arriving right after the stop sample is accepted; IDLE lasts at least 1 cycle.
- **Clear:** `receive_flag` falls 1 cycle after the clear strobe, and `int_req` falls 1 cycle after that.

## Configuration
- `UART_RX_OVERRUN_EN` defined:
  - adds output `overrun` (1 bit, reset 0);
  - `overrun` is set when a good frame completes while `receive_flag`=1 and the clear is not asserted in that same cycle;
  - `overrun` is cleared together with `receive_flag` by the 252-read strobe;
  - the same condition also sets bit 2 of the status mux output `status` = {5'b0, `overrun`, `receive_flag`, 1'b0}.
- `UART_RX_OVERRUN_EN` undefined:
  - no `overrun` port; the overwrite happens silently;
  - `status` bit 2 reads 0.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `rx_en`=1 unless stated.
- **Single frame:** send 0xA5 with a good stop bit → after the stop sample `rx_data`=0xA5 and `receive_flag`=1; `int_req`=1 one cycle later.
- **Clear:** with a byte pending, drive `access_addr`=252 and `reg_w_en`=1 for 1 cycle → `receive_flag`=0 next cycle, `int_req`=0 the cycle after; `rx_data` stays 0xA5.
- **Start glitch:** pull `rx` low for 5 cycles → FSM returns to IDLE; no flag change and no `frame_err`.
- **Framing error:** send 0x3C with the stop bit low → `frame_err`=1, `receive_flag` unchanged, `rx_data` keeps its old value. A following good 0x01 clears `frame_err` and gives `rx_data`=0x01.
- **Overrun and set-wins:**
  - send 0x11 then 0x22 with no read → `rx_data`=0x22 and `receive_flag`=1 (plus `overrun`=1 when `UART_RX_OVERRUN_EN` is defined);
  - a clear coinciding with the completion of 0x33 → `receive_flag` stays 1.
- **Abort and reset:**
  - drop `rx_en` at data bit 3 → FSM returns to IDLE and flags are retained;
  - assert `wb_rst_n_i`=0 mid-frame → all outputs are 0 immediately, and a fresh 0x5A is received correctly after release.
